// File: rtl/loop_counter_sched_pkg.sv
// Shared types and defaults for the loop counter scheduler.
// State encodings are fixed so that a state dump reads the same in every tool.
package loop_counter_sched_pkg;

  localparam int unsigned CntW  = 7;
  localparam int unsigned LoopW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } state_e;

  // A sequence counts as in flight while counting or paused.
  function automatic logic is_busy(input state_e st);
    return (st == StRun) || (st == StHold);
  endfunction

endpackage

// File: rtl/loop_cnt_core.sv
// Counter datapath for one pass: counts up to limit, then wraps back to 0.
// clr has priority over en.
module loop_cnt_core
  import loop_counter_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign at_limit = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_limit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/loop_counter_sched.sv
// Programmable pass sequencer around loop_cnt_core: start/pause/stop control,
// pass counting, and registered wrap/done pulses.
module loop_counter_sched
  import loop_counter_sched_pkg::*;
#(
  parameter int unsigned CNT_W  = CntW,
  parameter int unsigned LOOP_W = LoopW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [CNT_W-1:0]  limit,
  input  logic [LOOP_W-1:0] loops,
  output logic [CNT_W-1:0]  cnt,
  output logic [LOOP_W-1:0] loop_idx,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  limit_d, limit_q;
  logic [LOOP_W-1:0] loops_d, loops_q;
  logic [LOOP_W-1:0] loop_idx_d, loop_idx_q;
  logic              busy_d, busy_q;
  logic              wrap_d, wrap_q;
  logic              done_d, done_q;

  logic              cnt_en, cnt_clr, at_limit;
  logic [LOOP_W-1:0] loop_nxt;
  logic              last_pass;

  loop_cnt_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .limit   (limit_q),
    .cnt     (cnt),
    .at_limit(at_limit)
  );

  // loops_q == 0 means run until stopped, so it never marks a last pass.
  assign loop_nxt  = loop_idx_q + 1'b1;
  assign last_pass = (loops_q != '0) && (loop_nxt == loops_q);

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    loops_d    = loops_q;
    loop_idx_d = loop_idx_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_clr    = 1'b1;
        loop_idx_d = '0;
        if (start) begin
          state_d = StRun;
          limit_d = limit;
          loops_d = loops;
        end
      end

      StRun: begin
        if (stop) begin
          state_d    = StIdle;
          cnt_clr    = 1'b1;
          loop_idx_d = '0;
        end else if (pause) begin
          state_d = StHold;
        end else begin
          cnt_en = 1'b1;
          if (at_limit) begin
            wrap_d     = 1'b1;
            loop_idx_d = loop_nxt;
            if (last_pass) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
      end

      StHold: begin
        // Leaving HOLD does not count; the count resumes on the following edge.
        if (stop) begin
          state_d    = StIdle;
          cnt_clr    = 1'b1;
          loop_idx_d = '0;
        end else if (!pause) begin
          state_d = StRun;
        end
      end

      StDone: begin
        state_d    = StIdle;
        cnt_clr    = 1'b1;
        loop_idx_d = '0;
      end

      default: begin
        state_d    = StIdle;
        cnt_clr    = 1'b1;
        loop_idx_d = '0;
      end
    endcase

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      limit_q    <= '0;
      loops_q    <= '0;
      loop_idx_q <= '0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      loops_q    <= loops_d;
      loop_idx_q <= loop_idx_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
    end
  end

  assign loop_idx = loop_idx_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;
  assign done     = done_q;

endmodule

// File: tb/tb_loop_counter_sched.sv
// Directed bench for loop_counter_sched: a vector table for whole sequences
// plus hand-written pause, limit-0, hold-stop and async-reset sequences.
module tb_loop_counter_sched;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic [6:0] limit;
  logic [3:0] loops;
  logic [6:0] cnt;
  logic [3:0] loop_idx;
  logic       busy;
  logic       wrap;
  logic       done;

  int total;
  int bad;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       pause;
    logic [6:0] limit;
    logic [3:0] loops;
    logic [6:0] e_cnt;
    logic [3:0] e_idx;
    logic       e_busy;
    logic       e_wrap;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  loop_counter_sched #(
    .CNT_W (7),
    .LOOP_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .limit   (limit),
    .loops   (loops),
    .cnt     (cnt),
    .loop_idx(loop_idx),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] pk(input logic [6:0] c, input logic [3:0] i,
                                     input logic b, input logic w, input logic d);
    return {c, i, b, w, d};
  endfunction

  function automatic string fmt(input logic [13:0] v);
    return $sformatf("cnt=%0d idx=%0d busy=%0b wrap=%0b done=%0b",
                     v[13:7], v[6:3], v[2], v[1], v[0]);
  endfunction

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] got;
    got = {cnt, loop_idx, busy, wrap, done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic st, input logic p,
                       input logic [6:0] lim, input logic [3:0] lp);
    start = s;
    stop  = st;
    pause = p;
    limit = lim;
    loops = lp;
  endtask

  task automatic add(input logic s, input logic st, input logic p,
                     input logic [6:0] lim, input logic [3:0] lp,
                     input logic [6:0] c, input logic [3:0] i,
                     input logic b, input logic w, input logic d);
    vec_t v;
    v = '{start: s, stop: st, pause: p, limit: lim, loops: lp,
          e_cnt: c, e_idx: i, e_busy: b, e_wrap: w, e_done: d};
    tbl.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // limit=4, loops=2: two passes of five cycles, done on the second wrap.
    add(1, 0, 0, 4, 2, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 4, 2, 7'(k), 0, 1, 0, 0);
    add(0, 0, 0, 4, 2, 0, 1, 1, 1, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 4, 2, 7'(k), 1, 1, 0, 0);
    add(0, 0, 0, 4, 2, 0, 2, 0, 1, 1);
    add(1, 0, 0, 4, 2, 0, 0, 0, 0, 0);  // start seen in DONE is dropped
    add(0, 0, 0, 4, 2, 0, 0, 0, 0, 0);

    // limit=5, loops=3: stop at cnt=2 in the second pass.
    add(1, 0, 0, 5, 3, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 5, 3, 7'(k), 0, 1, 0, 0);
    add(0, 0, 0, 5, 3, 0, 1, 1, 1, 0);
    add(0, 0, 0, 5, 3, 1, 1, 1, 0, 0);
    add(0, 0, 0, 5, 3, 2, 1, 1, 0, 0);
    add(0, 1, 0, 5, 3, 0, 0, 0, 0, 0);
    add(0, 0, 0, 5, 3, 0, 0, 0, 0, 0);

    // limit=3, loops=1: restart attempt with new limit/loops mid-run is ignored.
    add(1, 0, 0, 3, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 20, 7, 1, 0, 1, 0, 0);
    add(0, 0, 0, 20, 7, 2, 0, 1, 0, 0);
    add(0, 0, 0, 20, 7, 3, 0, 1, 0, 0);
    add(0, 0, 0, 20, 7, 0, 1, 0, 1, 1);
    add(0, 0, 0, 20, 7, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #50;
    chk("in_reset", pk(0, 0, 0, 0, 0));
    #50;
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle[%0d]", k), pk(0, 0, 0, 0, 0));
    end

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].start, tbl[k].stop, tbl[k].pause, tbl[k].limit, tbl[k].loops);
      tick();
      chk($sformatf("vec[%0d]", k),
          pk(tbl[k].e_cnt, tbl[k].e_idx, tbl[k].e_busy, tbl[k].e_wrap, tbl[k].e_done));
    end

    // limit=9, loops=1 with pause held over five edges at cnt=3.
    drive(1, 0, 0, 9, 1);
    tick();
    chk("pause_start", pk(0, 0, 1, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("pause_ramp[%0d]", k), pk(7'(k), 0, 1, 0, 0));
    end
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("pause_hold[%0d]", k), pk(3, 0, 1, 0, 0));
    end
    pause = 1'b0;
    tick();
    chk("pause_resume", pk(3, 0, 1, 0, 0));
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk($sformatf("pause_tail[%0d]", k), pk(7'(k), 0, 1, 0, 0));
    end
    tick();
    chk("pause_done", pk(0, 1, 0, 1, 1));
    tick();
    chk("pause_idle", pk(0, 0, 0, 0, 0));

    // stop wins over pause while in HOLD.
    drive(1, 0, 0, 9, 1);
    tick();
    start = 1'b0;
    tick();
    chk("hold_run", pk(1, 0, 1, 0, 0));
    pause = 1'b1;
    tick();
    chk("hold_enter", pk(1, 0, 1, 0, 0));
    stop = 1'b1;
    tick();
    chk("hold_stop", pk(0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0);

    // limit=0, loops=0: wrap every RUN cycle, loop_idx rolls over, never done.
    drive(1, 0, 0, 0, 0);
    tick();
    chk("lim0_start", pk(0, 0, 1, 0, 0));
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] e_idx;
      e_idx = 4'(k);
      tick();
      chk($sformatf("lim0[%0d]", k), pk(0, e_idx, 1, 1, 0));
    end
    stop = 1'b1;
    tick();
    chk("lim0_stop", pk(0, 0, 0, 0, 0));
    stop = 1'b0;

    // Reset mid-pass clears outputs before the next clock edge.
    drive(1, 0, 0, 7, 2);
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_pre", pk(3, 0, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", pk(0, 0, 0, 0, 0));
    tick();
    chk("rst_held", pk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_idle", pk(0, 0, 0, 0, 0));
    drive(1, 0, 0, 2, 1);
    tick();
    chk("rst_restart", pk(0, 0, 1, 0, 0));
    start = 1'b0;
    tick();
    chk("rst_restart_cnt", pk(1, 0, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
